// File: rtl/tlb_op_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_op_ctrl
//
// Sequencer for the TLB-management instructions (TLBSRCH, TLBRD, TLBWR,
// TLBFILL, INVTLB) issued from the writeback stage. It takes one operation per
// op_valid/op_ready handshake and drives search port 1, the read port, the
// write port and the invtlb port of a dual-search TLB. Results are registered
// so the CSR file can update TLBIDX, TLBEHI, TLBELO0/1 and ASID.
//
// Timing: accept at edge N, execute in cycle N+1, done pulse in cycle N+2,
// back in IDLE for cycle N+3. Illegal requests skip the execute cycle.
//
// Ports
//   clk, resetn      clock (rising edge) / asynchronous active-low reset
//   flush            cancels any in-flight op; blocks acceptance while high
//   op_valid/ready   request handshake (ready only in IDLE)
//   op_code          0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5-7 illegal
//   inv_op/asid/vppn INVTLB operands
//   csr_asid/vppn    CSR.ASID.ASID / CSR.TLBEHI.VPPN
//   csr_index        CSR.TLBIDX.INDEX
//   csr_entry        packed entry for WR/FILL
//   tlb_s_*          search port 1 (vppn/asid out, found/index in)
//   tlb_r_*          read port (index out, packed entry in)
//   tlb_we/w_*       write port
//   tlb_inv_*        invtlb port
//   done/done_err    completion pulse / illegal-request flag
//   res_found/index  TLBSRCH result
//   res_entry        TLBRD result
//
// Entry layout MSB->LSB: e vppn(19) ps(6) asid(10) g ppn0(20) plv0(2) mat0(2)
// d0 v0 ppn1(20) plv1(2) mat1(2) d1 v1.
// -----------------------------------------------------------------------------
module tlb_op_ctrl #(
  parameter int TLBNUM  = 16,
  parameter int IDXW    = 4,
  parameter int ENTRY_W = 89
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [2:0]         op_code,
  input  logic [4:0]         inv_op,
  input  logic [9:0]         inv_asid,
  input  logic [18:0]        inv_vppn,
  input  logic [9:0]         csr_asid,
  input  logic [18:0]        csr_vppn,
  input  logic [IDXW-1:0]    csr_index,
  input  logic [ENTRY_W-1:0] csr_entry,
  output logic [18:0]        tlb_s_vppn,
  output logic [9:0]         tlb_s_asid,
  input  logic               tlb_s_found,
  input  logic [IDXW-1:0]    tlb_s_index,
  output logic [IDXW-1:0]    tlb_r_index,
  input  logic [ENTRY_W-1:0] tlb_r_entry,
  output logic               tlb_we,
  output logic [IDXW-1:0]    tlb_w_index,
  output logic [ENTRY_W-1:0] tlb_w_entry,
  output logic               tlb_inv_valid,
  output logic [4:0]         tlb_inv_op,
  output logic               done,
  output logic               done_err,
  output logic               res_found,
  output logic [IDXW-1:0]    res_index,
  output logic [ENTRY_W-1:0] res_entry
);

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam logic [IDXW-1:0] FILL_LAST = IDXW'(TLBNUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRCH,
    S_RD,
    S_WR,
    S_INV,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_accept;
  logic                 w_illegal;

  logic [4:0]           r_inv_op;
  logic [9:0]           r_inv_asid;
  logic [18:0]          r_inv_vppn;
  logic [9:0]           r_asid;
  logic [18:0]          r_vppn;
  logic [IDXW-1:0]      r_index;
  logic [IDXW-1:0]      r_w_index;
  logic [ENTRY_W-1:0]   r_entry;
  logic [IDXW-1:0]      r_fill_ptr;

  logic                 r_done;
  logic                 r_done_err;
  logic                 r_res_found;
  logic [IDXW-1:0]      r_res_index;
  logic [ENTRY_W-1:0]   r_res_entry;

  assign w_accept  = op_valid && (r_state == S_IDLE) && !flush;
  assign w_illegal = (op_code > OP_INV) || ((op_code == OP_INV) && (inv_op > 5'd6));

  // Next-state logic. Flush overrides everything outside IDLE, which also
  // suppresses the done pulse because done is derived from entering S_DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_illegal) begin
            w_next = S_DONE;
          end else begin
            case (op_code)
              OP_SRCH: w_next = S_SRCH;
              OP_RD:   w_next = S_RD;
              OP_WR:   w_next = S_WR;
              OP_FILL: w_next = S_WR;
              default: w_next = S_INV;
            endcase
          end
        end
      end
      S_SRCH, S_RD, S_WR, S_INV: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush && (r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Free-running fill pointer; FILL uses whatever value it holds at accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fill_ptr <= '0;
    end else if (r_fill_ptr == FILL_LAST) begin
      r_fill_ptr <= '0;
    end else begin
      r_fill_ptr <= r_fill_ptr + 1'b1;
    end
  end

  // Operand capture at acceptance; the CSR inputs may change afterwards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_inv_op   <= '0;
      r_inv_asid <= '0;
      r_inv_vppn <= '0;
      r_asid     <= '0;
      r_vppn     <= '0;
      r_index    <= '0;
      r_w_index  <= '0;
      r_entry    <= '0;
    end else if (w_accept) begin
      r_inv_op   <= inv_op;
      r_inv_asid <= inv_asid;
      r_inv_vppn <= inv_vppn;
      r_asid     <= csr_asid;
      r_vppn     <= csr_vppn;
      r_index    <= csr_index;
      r_w_index  <= (op_code == OP_FILL) ? r_fill_ptr : csr_index;
      r_entry    <= csr_entry;
    end
  end

  // Completion flags and result registers. Results are taken at the end of
  // the execute cycle unless that cycle is flushed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_done      <= 1'b0;
      r_done_err  <= 1'b0;
      r_res_found <= 1'b0;
      r_res_index <= '0;
      r_res_entry <= '0;
    end else begin
      r_done     <= (w_next == S_DONE);
      r_done_err <= (w_next == S_DONE) && (r_state == S_IDLE);
      if ((r_state == S_SRCH) && !flush) begin
        r_res_found <= tlb_s_found;
        r_res_index <= tlb_s_found ? tlb_s_index : '0;
      end
      if ((r_state == S_RD) && !flush) begin
        // An invalid entry reads back as all zeros.
        r_res_entry <= tlb_r_entry[ENTRY_W-1] ? tlb_r_entry : '0;
      end
    end
  end

  // Search port is shared: INV uses its own operands, SRCH the latched CSR
  // values, and every other state passes the live CSR values straight through.
  always_comb begin
    tlb_s_vppn = csr_vppn;
    tlb_s_asid = csr_asid;
    case (r_state)
      S_SRCH: begin
        tlb_s_vppn = r_vppn;
        tlb_s_asid = r_asid;
      end
      S_INV: begin
        tlb_s_vppn = r_inv_vppn;
        tlb_s_asid = r_inv_asid;
      end
      default: begin
        tlb_s_vppn = csr_vppn;
        tlb_s_asid = csr_asid;
      end
    endcase
  end

  assign op_ready      = (r_state == S_IDLE);
  assign tlb_r_index   = r_index;
  assign tlb_we        = (r_state == S_WR) && !flush;
  assign tlb_w_index   = r_w_index;
  assign tlb_w_entry   = r_entry;
  assign tlb_inv_valid = (r_state == S_INV) && !flush;
  assign tlb_inv_op    = r_inv_op;

  assign done      = r_done;
  assign done_err  = r_done_err;
  assign res_found = r_res_found;
  assign res_index = r_res_index;
  assign res_entry = r_res_entry;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
module tb_tlb_op_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        flush = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_code = '0;
  logic [4:0]  inv_op = '0;
  logic [9:0]  inv_asid = '0;
  logic [18:0] inv_vppn = '0;
  logic [9:0]  csr_asid = '0;
  logic [18:0] csr_vppn = '0;
  logic [3:0]  csr_index = '0;
  logic [88:0] csr_entry = '0;
  logic [18:0] tlb_s_vppn;
  logic [9:0]  tlb_s_asid;
  logic        tlb_s_found;
  logic [3:0]  tlb_s_index;
  logic [3:0]  tlb_r_index;
  logic [88:0] tlb_r_entry;
  logic        tlb_we;
  logic [3:0]  tlb_w_index;
  logic [88:0] tlb_w_entry;
  logic        tlb_inv_valid;
  logic [4:0]  tlb_inv_op;
  logic        done;
  logic        done_err;
  logic        res_found;
  logic [3:0]  res_index;
  logic [88:0] res_entry;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tlb_op_ctrl dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .csr_asid(csr_asid), .csr_vppn(csr_vppn), .csr_index(csr_index),
    .csr_entry(csr_entry),
    .tlb_s_vppn(tlb_s_vppn), .tlb_s_asid(tlb_s_asid),
    .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
    .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
    .tlb_inv_valid(tlb_inv_valid), .tlb_inv_op(tlb_inv_op),
    .done(done), .done_err(done_err),
    .res_found(res_found), .res_index(res_index), .res_entry(res_entry)
  );

  // ---------------- behavioural 16-entry TLB ----------------
  logic [88:0] mem [16] = '{default: '0};

  function automatic logic inv_hit(input logic [88:0] e, input logic [4:0] op,
                                   input logic [9:0] a, input logic [18:0] vp);
    logic g, am, vm;
    g  = e[52];
    am = (e[62:53] == a);
    vm = (e[87:69] == vp);
    case (op)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return g;
      5'd3:       return !g;
      5'd4:       return !g && am;
      5'd5:       return !g && am && vm;
      5'd6:       return (g || am) && vm;
      default:    return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (tlb_we) mem[tlb_w_index] <= tlb_w_entry;
    if (tlb_inv_valid)
      for (int i = 0; i < 16; i++)
        if (inv_hit(mem[i], tlb_inv_op, tlb_s_asid, tlb_s_vppn)) mem[i][88] <= 1'b0;
  end

  always_comb begin
    tlb_s_found = 1'b0;
    tlb_s_index = '0;
    for (int i = 0; i < 16; i++) begin
      if (!tlb_s_found && mem[i][88] && (mem[i][87:69] == tlb_s_vppn) &&
          (mem[i][52] || (mem[i][62:53] == tlb_s_asid))) begin
        tlb_s_found = 1'b1;
        tlb_s_index = 4'(i);
      end
    end
  end

  assign tlb_r_entry = mem[tlb_r_index];

  // Model of the free-running fill counter.
  int fp;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) fp <= 0;
    else         fp <= (fp == 15) ? 0 : fp + 1;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  iop;
    logic [9:0]  iasid;
    logic [18:0] ivppn;
    logic [9:0]  asid;
    logic [18:0] vppn;
    logic [3:0]  idx;
    logic [88:0] ent;
    int          lat;     // cycles from accept edge to done
    logic        err;
    int          we_n;
    int          inv_n;
    int          kind;    // 0 none, 1 check search result, 2 check read result
    logic        found;
    logic [3:0]  ridx;
    logic [88:0] rent;
  } vec_t;

  localparam logic [88:0] E5 = {1'b1, 19'h12345, 6'd12, 10'd3, 1'b0,
                                20'hABCDE, 2'd3, 2'd1, 1'b1, 1'b1,
                                20'h54321, 2'd0, 2'd1, 1'b0, 1'b1};
  localparam logic [88:0] E7 = {1'b0, 19'h7FFFF, 6'd21, 10'h155, 1'b1,
                                20'hFFFFF, 2'd3, 2'd3, 1'b1, 1'b1,
                                20'h0F0F0, 2'd2, 2'd2, 1'b1, 1'b0};

  function automatic vec_t mk(input logic [2:0] op, input logic [4:0] iop,
                              input logic [9:0] asid, input logic [18:0] vppn,
                              input logic [3:0] idx, input logic [88:0] ent,
                              input int lat, input logic err, input int we_n,
                              input int inv_n, input int kind, input logic found,
                              input logic [3:0] ridx, input logic [88:0] rent);
    vec_t v;
    v.op = op; v.iop = iop; v.iasid = asid; v.ivppn = vppn;
    v.asid = asid; v.vppn = vppn; v.idx = idx; v.ent = ent;
    v.lat = lat; v.err = err; v.we_n = we_n; v.inv_n = inv_n;
    v.kind = kind; v.found = found; v.ridx = ridx; v.rent = rent;
    return v;
  endfunction

  // Runs one op; returns at the negedge of the done cycle (N+2) so a following
  // call accepts at edge N+3, one bubble later.
  task automatic run_op(input vec_t v, input int wait_fp, output logic [3:0] o_widx);
    int we_n, inv_n, done_n, done_k, both_n, g;
    logic [3:0]  we_idx, exp_widx;
    logic [88:0] we_ent;
    logic [4:0]  iop_s;
    logic [18:0] iv_s;
    logic [9:0]  ia_s;
    logic        err_s;
    we_n = 0; inv_n = 0; done_n = 0; done_k = 0; both_n = 0; err_s = 1'b0;
    we_idx = '0; we_ent = '0; iop_s = '0; iv_s = '0; ia_s = '0;
    @(negedge clk);
    g = 0;
    while (wait_fp >= 0 && fp != wait_fp && g < 40) begin
      @(negedge clk);
      g++;
    end
    op_code = v.op; inv_op = v.iop; inv_asid = v.iasid; inv_vppn = v.ivppn;
    csr_asid = v.asid; csr_vppn = v.vppn; csr_index = v.idx; csr_entry = v.ent;
    #1;
    chk("op_ready_idle", op_ready, 1);
    chk("s_vppn_idle_passthru", tlb_s_vppn, v.vppn);
    exp_widx = (v.op == 3'd3) ? 4'(fp) : v.idx;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    // Scramble live inputs so only latched operands can produce right answers.
    csr_entry = ~v.ent; csr_index = ~v.idx; csr_vppn = ~v.vppn; csr_asid = ~v.asid;
    inv_op = ~v.iop; inv_asid = ~v.iasid; inv_vppn = ~v.ivppn;
    for (int k = 1; k <= 2; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) chk("op_ready_busy", op_ready, 0);
      if (tlb_we) begin we_n++; we_idx = tlb_w_index; we_ent = tlb_w_entry; end
      if (tlb_inv_valid) begin inv_n++; iop_s = tlb_inv_op; iv_s = tlb_s_vppn; ia_s = tlb_s_asid; end
      if (tlb_we && tlb_inv_valid) both_n++;
      if (done) begin
        done_n++;
        if (done_k == 0) done_k = k;
        err_s = done_err;
      end
    end
    chk("done_latency", done_k, v.lat);
    chk("done_single", done_n, 1);
    chk("done_err", err_s, v.err);
    chk("we_pulses", we_n, v.we_n);
    chk("inv_pulses", inv_n, v.inv_n);
    chk("we_inv_exclusive", both_n, 0);
    if (v.we_n > 0) begin
      chk("w_index", we_idx, exp_widx);
      chk("w_entry", we_ent, v.ent);
    end
    if (v.inv_n > 0) begin
      chk("inv_op", iop_s, v.iop);
      chk("inv_s_vppn", iv_s, v.ivppn);
      chk("inv_s_asid", ia_s, v.iasid);
    end
    if (v.kind == 1) begin
      chk("res_found", res_found, v.found);
      chk("res_index", res_index, v.ridx);
    end
    if (v.kind == 2) chk("res_entry", res_entry, v.rent);
    o_widx = we_idx;
  endtask

  vec_t vecs [11];
  logic [3:0] widx1, widx2;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(3'd2, 5'd0, 10'd3, 19'h12345, 4'd5, E5, 2, 1'b0, 1, 0, 0, 1'b0, 4'd0, '0);
    vecs[1]  = mk(3'd2, 5'd0, 10'd0, 19'h00000, 4'd7, E7, 2, 1'b0, 1, 0, 0, 1'b0, 4'd0, '0);
    vecs[2]  = mk(3'd0, 5'd0, 10'd3, 19'h12345, 4'd0, '0, 2, 1'b0, 0, 0, 1, 1'b1, 4'd5, '0);
    vecs[3]  = mk(3'd0, 5'd0, 10'd4, 19'h12345, 4'd0, '0, 2, 1'b0, 0, 0, 1, 1'b0, 4'd0, '0);
    vecs[4]  = mk(3'd1, 5'd0, 10'd0, 19'h00000, 4'd5, '0, 2, 1'b0, 0, 0, 2, 1'b0, 4'd0, E5);
    vecs[5]  = mk(3'd1, 5'd0, 10'd0, 19'h00000, 4'd7, '0, 2, 1'b0, 0, 0, 2, 1'b0, 4'd0, '0);
    vecs[6]  = mk(3'd6, 5'd0, 10'd0, 19'h00000, 4'd1, E5, 1, 1'b1, 0, 0, 0, 1'b0, 4'd0, '0);
    vecs[7]  = mk(3'd4, 5'd5, 10'd3, 19'h12345, 4'd0, '0, 2, 1'b0, 0, 1, 0, 1'b0, 4'd0, '0);
    vecs[8]  = mk(3'd0, 5'd0, 10'd3, 19'h12345, 4'd0, '0, 2, 1'b0, 0, 0, 1, 1'b0, 4'd0, '0);
    vecs[9]  = mk(3'd4, 5'd9, 10'd3, 19'h12345, 4'd0, '0, 1, 1'b1, 0, 0, 0, 1'b0, 4'd0, '0);
    vecs[10] = mk(3'd1, 5'd0, 10'd0, 19'h00000, 4'd5, '0, 2, 1'b0, 0, 0, 2, 1'b0, 4'd0, '0);

    // Reset state
    #3 resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_done_err", done_err, 0);
    chk("rst_res_found", res_found, 0);
    chk("rst_res_index", res_index, 0);
    chk("rst_res_entry", res_entry, 0);
    chk("rst_tlb_we", tlb_we, 0);
    chk("rst_inv_valid", tlb_inv_valid, 0);

    // Reset in the middle of a WR
    op_code = 3'd2; csr_index = 4'd9; csr_entry = E5; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    chk("midwr_we_active", tlb_we, 1);
    #2 resetn = 1'b0;
    #1 chk("midwr_we_dropped", tlb_we, 0);
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);
    chk("midwr_op_ready", op_ready, 1);
    chk("midwr_no_write", mem[9], '0);
    chk("midwr_done", done, 0);
    chk("midwr_res_entry", res_entry, 0);

    // Table of directed ops
    for (int i = 0; i < 11; i++) run_op(vecs[i], -1, widx1);

    // FILL at fill_ptr 15, then a back-to-back FILL on the wrapped count
    run_op(mk(3'd3, 5'd0, 10'd1, 19'h00ABC, 4'd0, E5, 2, 1'b0, 1, 0, 0, 1'b0, 4'd0, '0), 15, widx1);
    chk("fill_first_idx", widx1, 4'd15);
    run_op(mk(3'd3, 5'd0, 10'd1, 19'h00ABC, 4'd0, E7, 2, 1'b0, 1, 0, 0, 1'b0, 4'd0, '0), -1, widx2);
    chk("fill_wrap_le3", widx2 <= 4'd3, 1);

    // Flush while in WR
    @(negedge clk);
    op_code = 3'd2; csr_index = 4'd9; csr_entry = E5; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_wr_we", tlb_we, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_wr_idle", op_ready, 1);
    chk("flush_wr_no_done", done, 0);
    @(negedge clk);
    chk("flush_wr_no_done2", done, 0);
    chk("flush_wr_no_write", mem[9], '0);

    // Flush while in INV
    op_code = 3'd4; inv_op = 5'd0; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_inv_valid", tlb_inv_valid, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_inv_idle", op_ready, 1);
    chk("flush_inv_no_done", done, 0);

    // Flush in IDLE holds off a pending request
    @(negedge clk);
    flush = 1'b1; op_code = 3'd0; csr_vppn = 19'h00ABC; csr_asid = 10'd1; op_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_idle_blocked", op_ready, 1);
      chk("flush_idle_no_done", done, 0);
    end
    flush = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    chk("flush_drop_accepted", op_ready, 0);
    @(negedge clk);
    chk("flush_drop_done", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
